// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generation stage: widths, reset vector,
// FSM state encoding and the instruction-length helper.
package pc_gen_pkg;

   localparam int          PCG_XLEN     = 32;
   localparam logic [31:0] PCG_RESET_PC = 32'h3000_0000;

   typedef enum logic [1:0] {
      PCG_IDLE  = 2'd0,
      PCG_FETCH = 2'd1,
      PCG_DRAIN = 2'd2
   } pcg_state_e;

   // Fetched-instruction length in bytes: 2'b11 in the low bits marks a 32-bit op.
   function automatic logic [2:0] pcg_inst_len(input logic [1:0] inst_lo);
      logic [2:0] len;
      if (inst_lo == 2'b11) begin
         len = 3'd4;
      end else begin
         len = 3'd2;
      end
      return len;
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between pc_gen (master), the redirect sources and the icache/ifu.
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            stall_i;
   logic            fetch_ack_i;
   logic [1:0]      inst_lo_i;
   logic            trap_valid_i;
   logic [XLEN-1:0] trap_pc_i;
   logic            ex_redirect_valid_i;
   logic [XLEN-1:0] ex_redirect_pc_i;
   logic            bpu_valid_i;
   logic [XLEN-1:0] bpu_pc_i;
   logic [XLEN-1:0] pc_o;
   logic            req_valid_o;
   logic            kill_o;
   logic            misaligned_o;

   modport master (
      input  stall_i, fetch_ack_i, inst_lo_i, trap_valid_i, trap_pc_i,
             ex_redirect_valid_i, ex_redirect_pc_i, bpu_valid_i, bpu_pc_i,
      output pc_o, req_valid_o, kill_o, misaligned_o
   );

   modport slave (
      output stall_i, fetch_ack_i, inst_lo_i, trap_valid_i, trap_pc_i,
             ex_redirect_valid_i, ex_redirect_pc_i, bpu_valid_i, bpu_pc_i,
      input  pc_o, req_valid_o, kill_o, misaligned_o
   );
endinterface

// File: rtl/pc_gen_next_sel.sv
// Next-PC priority mux (trap > EX redirect > BPU > sequential) and the sequential adder.
module pc_gen_next_sel
   import pc_gen_pkg::*;
#(
   parameter int XLEN = PCG_XLEN
) (
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      inst_lo,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            bpu_valid,
   input  logic [XLEN-1:0] bpu_pc,
   output logic            redir,
   output logic [XLEN-1:0] rtgt,
   output logic [XLEN-1:0] next_pc
);

   logic [XLEN-1:0] seq_s;

   // Adder wraps naturally at 2^XLEN.
   assign seq_s = pc + XLEN'(pcg_inst_len(inst_lo));
   assign redir = trap_valid | ex_valid;

   // Redirect target and full priority selection; BPU never beats a redirect.
   always_comb begin
      rtgt    = ex_pc;
      next_pc = seq_s;
      if (trap_valid) begin
         rtgt = trap_pc;
      end else begin
         rtgt = ex_pc;
      end
      if (redir) begin
         next_pc = rtgt;
      end else if (bpu_valid) begin
         next_pc = bpu_pc;
      end else begin
         next_pc = seq_s;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// PC generation stage: owns the fetch PC, issues fetch requests and squashes
// responses that belong to a request overtaken by a redirect.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN     = PCG_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(PCG_RESET_PC)
) (
   input logic       clk,
   input logic       rst,
   pc_gen_if.master  bus
);

   pcg_state_e      state_r, state_nxt_s;
   logic [XLEN-1:0] pc_r, pc_nxt_s;
   logic [XLEN-1:0] pend_pc_r, pend_pc_nxt_s;
   logic            pend_trap_r, pend_trap_nxt_s;
   logic            req_valid_r;
   logic            kill_s;
   logic            accept_s;
   logic            redir_s;
   logic [XLEN-1:0] rtgt_s;
   logic [XLEN-1:0] next_pc_s;

   assign accept_s = bus.fetch_ack_i & ~bus.stall_i;

   pc_gen_next_sel #(.XLEN(XLEN)) u_next_sel (
      .pc         (pc_r),
      .inst_lo    (bus.inst_lo_i),
      .trap_valid (bus.trap_valid_i),
      .trap_pc    (bus.trap_pc_i),
      .ex_valid   (bus.ex_redirect_valid_i),
      .ex_pc      (bus.ex_redirect_pc_i),
      .bpu_valid  (bus.bpu_valid_i),
      .bpu_pc     (bus.bpu_pc_i),
      .redir      (redir_s),
      .rtgt       (rtgt_s),
      .next_pc    (next_pc_s)
   );

   // Next-state, next-PC and pending-redirect bookkeeping.
   always_comb begin
      state_nxt_s     = state_r;
      pc_nxt_s        = pc_r;
      pend_pc_nxt_s   = pend_pc_r;
      pend_trap_nxt_s = pend_trap_r;
      kill_s          = 1'b0;
      case (state_r)
         PCG_IDLE: begin
            state_nxt_s = PCG_FETCH;
            if (redir_s) begin
               pc_nxt_s = rtgt_s;
            end else begin
               pc_nxt_s = pc_r;
            end
         end
         PCG_FETCH: begin
            if (accept_s) begin
               pc_nxt_s = next_pc_s;
            end else if (redir_s && !bus.fetch_ack_i) begin
               // Request already on the bus: park the target until its response returns.
               pend_pc_nxt_s   = rtgt_s;
               pend_trap_nxt_s = bus.trap_valid_i;
               state_nxt_s     = PCG_DRAIN;
            end else if (redir_s) begin
               pc_nxt_s = rtgt_s;
            end else begin
               pc_nxt_s = pc_r;
            end
         end
         PCG_DRAIN: begin
            if (bus.fetch_ack_i) begin
               kill_s          = 1'b1;
               state_nxt_s     = PCG_FETCH;
               pend_trap_nxt_s = 1'b0;
               if (bus.trap_valid_i) begin
                  pc_nxt_s = bus.trap_pc_i;
               end else if (bus.ex_redirect_valid_i && !pend_trap_r) begin
                  pc_nxt_s = bus.ex_redirect_pc_i;
               end else begin
                  pc_nxt_s = pend_pc_r;
               end
            end else if (bus.trap_valid_i) begin
               pend_pc_nxt_s   = bus.trap_pc_i;
               pend_trap_nxt_s = 1'b1;
            end else if (bus.ex_redirect_valid_i && !pend_trap_r) begin
               pend_pc_nxt_s = bus.ex_redirect_pc_i;
            end else begin
               pend_pc_nxt_s = pend_pc_r;
            end
         end
         default: begin
            state_nxt_s = PCG_IDLE;
            pc_nxt_s    = RESET_PC;
         end
      endcase
   end

   // State and PC registers; reset discards any pending redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= PCG_IDLE;
         pc_r        <= RESET_PC;
         pend_pc_r   <= '0;
         pend_trap_r <= 1'b0;
         req_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         pend_pc_r   <= pend_pc_nxt_s;
         pend_trap_r <= pend_trap_nxt_s;
         req_valid_r <= (state_nxt_s != PCG_IDLE);
      end
   end

   assign bus.pc_o         = pc_r;
   assign bus.req_valid_o  = req_valid_r;
   assign bus.kill_o       = kill_s;
   assign bus.misaligned_o = pc_r[0];

endmodule
